cache_mem_arbiter: RTL and testbench
====================================

// Module: cache_mem_arbiter
// PURPOSE
//  Shares the single physical-memory port (cacheline adaptor side) between the I-cache and D-cache.
//  Sits between both cache miss paths and pmem. Serves one 256-bit line transaction at a time.
//  D-cache has priority, with an anti-starvation limit that guarantees I-cache fetch progress.
//  Address to pmem is the latched grant address (replaces a free-running address mux select).
// PARAMETERS
//  LINE_W        256  cacheline width in bits
//  ADDR_W        32   byte address width
//  STARVE_LIMIT  4    consecutive D grants while I waits before I is forced to win (>=1)
//  CNT_W         32   perf counter width (matches perf_counter_width)
// PORTS
//  clk            in   1       clock, all state updates on rising edge
//  rst            in   1       asynchronous, active-high reset
//  i_read         in   1       I-cache line read request, held until i_resp
//  i_address      in   ADDR_W  I-cache line address
//  i_rdata        out  LINE_W  line returned to I-cache
//  i_resp         out  1       one-cycle completion pulse to I-cache
//  d_read         in   1       D-cache line read request, held until d_resp
//  d_write        in   1       D-cache writeback request, held until d_resp
//  d_address      in   ADDR_W  D-cache line address
//  d_wdata        in   LINE_W  D-cache writeback line
//  d_rdata        out  LINE_W  line returned to D-cache
//  d_resp         out  1       one-cycle completion pulse to D-cache
//  pmem_read      out  1       read request to pmem
//  pmem_write     out  1       write request to pmem
//  pmem_address   out  ADDR_W  line-aligned address to pmem (bits [4:0] forced 0)
//  pmem_wdata     out  LINE_W  write line to pmem
//  pmem_rdata     in   LINE_W  line from pmem
//  pmem_resp      in   1       pmem completion pulse
// BEHAVIOUR
//  - FSM states IDLE, SERVE_I, SERVE_D. Reset: state=IDLE, starve_cnt=0, latched addr/wdata/op=0;
//    all outputs 0 (pmem_read/write drop immediately on rst assertion, no clock needed).
//  - IDLE: d_req=d_read|d_write. If d_req && !(i_read && starve_cnt>=STARVE_LIMIT) -> SERVE_D;
//    else if i_read -> SERVE_I; else stay. Grant decision registered; latch addr, wdata, op at edge.
//  - starve_cnt: +1 (saturating at STARVE_LIMIT) on each D grant while i_read=1; cleared on I grant
//    or on any IDLE cycle with i_read=0.
//  - SERVE_x: pmem_read/pmem_write driven from latched op, pmem_address from latched addr.
//    d_write && d_read both high is illegal; write wins.
//  - On pmem_resp in SERVE_x: x_resp=1 and x_rdata=pmem_rdata same cycle (combinational);
//    next state IDLE. Other requester's resp/rdata stay 0 (rdata outputs are 0 when resp=0).
//  - Minimum 1 IDLE cycle between transactions; request->pmem request latency = 1 cycle.
//  - Requester dropping its request mid-transaction is ignored: transaction completes, resp pulses.
//  - pmem_resp outside SERVE states ignored. Request inputs changing during SERVE ignored (latched).
//  - rst mid-transaction: abort to IDLE; no resp issued; pmem side must also be reset.
// CONFIGURATION
//  ARB_PERF_COUNTERS_EN defined: adds outputs i_grant_cnt, d_grant_cnt, i_wait_cnt (CNT_W each,
//   saturating, reset 0): grants per requester and cycles with i_read=1 but state!=SERVE_I.
//  Undefined: ports and counters absent; arbitration behaviour identical.
// TESTING
//  1. i_read=1, addr 0x60 alone -> SERVE_I next cycle, pmem_read=1, pmem_address=0x60; pmem_resp -> i_resp 1 cycle, i_rdata=pmem_rdata.
//  2. i_read & d_write (addr 0x1234 -> pmem 0x1220) same cycle -> D served first with pmem_write, then I after 1 IDLE cycle.
//  3. i_read held, d_read re-asserted after every d_resp -> exactly STARVE_LIMIT(4) D grants, then I granted.
//  4. rst asserted mid SERVE_D -> pmem_read/write 0 same cycle, no d_resp, state IDLE; resume serves cleanly.
//  5. d_read dropped during SERVE_D, then pmem_resp -> d_resp still pulses once; spurious pmem_resp in IDLE -> no resp.
//  6. With ARB_PERF_COUNTERS_EN: run test 2 -> d_grant_cnt=1, i_grant_cnt=1, i_wait_cnt=cycles I waited.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one pmem line port between I-cache and D-cache; optional ARB_PERF_COUNTERS_EN adds grant/wait counters
module cache_mem_arbiter #(
    parameter int LINE_W       = 256,
    parameter int ADDR_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
`ifdef ARB_PERF_COUNTERS_EN
    ,
    output logic [CNT_W-1:0]  i_grant_cnt,
    output logic [CNT_W-1:0]  d_grant_cnt,
    output logic [CNT_W-1:0]  i_wait_cnt
`endif
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
    state_t state, state_nx;
    logic [SW-1:0] starve_cnt, starve_nx;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic op_write, grant_i, grant_d, starved;
    // grant decision, starvation tracking and next state
    always_comb begin
        starved = i_read && (starve_cnt >= SW'(STARVE_LIMIT));
        grant_d = (state == IDLE) && (d_read || d_write) && !starved;
        grant_i = (state == IDLE) && !grant_d && i_read;
        state_nx = grant_d ? SERVE_D : grant_i ? SERVE_I : (state != IDLE && pmem_resp) ? IDLE : state;
        starve_nx = starve_cnt;
        if (state == IDLE)
            starve_nx = (grant_i || !i_read) ? '0 :
                        (grant_d && starve_cnt != SW'(STARVE_LIMIT)) ? starve_cnt + 1'b1 : starve_cnt;
    end
    // state register plus transaction latch taken at the grant edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            starve_cnt <= '0;
            addr <= '0;
            wdata <= '0;
            op_write <= 1'b0;
        end else begin
            state <= state_nx;
            starve_cnt <= starve_nx;
            if (grant_d || grant_i) begin
                addr <= grant_d ? d_address : i_address;
                wdata <= grant_d ? d_wdata : '0;
                op_write <= grant_d && d_write;
            end
        end
    end
    assign pmem_read    = (state != IDLE) && !op_write;
    assign pmem_write   = (state != IDLE) && op_write;
    assign pmem_address = addr & ~ADDR_W'(31);
    assign pmem_wdata   = wdata;
    assign i_resp       = (state == SERVE_I) && pmem_resp;
    assign d_resp       = (state == SERVE_D) && pmem_resp;
    assign i_rdata      = i_resp ? pmem_rdata : '0;
    assign d_rdata      = d_resp ? pmem_rdata : '0;
`ifdef ARB_PERF_COUNTERS_EN
    // saturating grant and I-wait counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_grant_cnt <= '0;
            d_grant_cnt <= '0;
            i_wait_cnt <= '0;
        end else begin
            if (grant_i && i_grant_cnt != '1) i_grant_cnt <= i_grant_cnt + 1'b1;
            if (grant_d && d_grant_cnt != '1) d_grant_cnt <= d_grant_cnt + 1'b1;
            if (i_read && state != SERVE_I && i_wait_cnt != '1) i_wait_cnt <= i_wait_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter: directed scoreboard bench for cache_mem_arbiter
module tb_cache_mem_arbiter;
    logic clk = 1'b0, rst = 1'b1;
    logic i_read = 1'b0, d_read = 1'b0, d_write = 1'b0, pmem_resp = 1'b0;
    logic [31:0] i_address = '0, d_address = '0, pmem_address;
    logic [255:0] d_wdata = '0, pmem_rdata = '0, i_rdata, d_rdata, pmem_wdata;
    logic i_resp, d_resp, pmem_read, pmem_write;
    int total = 0, passed = 0, failed = 0;
    typedef struct {
        logic d;
        logic wr;
        logic [31:0] addr;
        logic [255:0] wdata;
    } txn_t;
    txn_t exp_q[$];

    cache_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // wait for the pmem request of the queue-front transaction and check it
    task automatic start_check();
        int n;
        txn_t e;
        e = exp_q[0];
        for (n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (pmem_read || pmem_write) break;
        end
        chk("grant_latency", 256'(n), 256'(1));
        chk("pmem_read", 256'(pmem_read), 256'(!e.wr));
        chk("pmem_write", 256'(pmem_write), 256'(e.wr));
        chk("pmem_address", 256'(pmem_address), 256'(e.addr));
        if (e.wr) chk("pmem_wdata", pmem_wdata, e.wdata);
    endtask

    // complete the queue-front transaction and drop its requester
    task automatic finish_txn();
        txn_t e;
        logic [255:0] line;
        e = exp_q.pop_front();
        line = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        pmem_rdata = line;
        pmem_resp = 1'b1;
        #1;
        chk("i_resp", 256'(i_resp), 256'(!e.d));
        chk("d_resp", 256'(d_resp), 256'(e.d));
        chk("i_rdata", i_rdata, e.d ? 256'(0) : line);
        chk("d_rdata", d_rdata, e.d ? line : 256'(0));
        @(negedge clk);
        pmem_resp = 1'b0;
        #1;
        chk("resp_one_cycle", 256'(i_resp | d_resp), 256'(0));
        if (e.d) begin
            d_read = 1'b0;
            d_write = 1'b0;
        end else i_read = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        chk("rst_pmem_read", 256'(pmem_read), 256'(0));
        chk("rst_pmem_write", 256'(pmem_write), 256'(0));
        chk("rst_pmem_address", 256'(pmem_address), 256'(0));
        chk("rst_resp", 256'({i_resp, d_resp}), 256'(0));
        rst = 1'b0;
        @(negedge clk);
        // 1: lone I read
        i_read = 1'b1;
        i_address = 32'h60;
        exp_q.push_back('{1'b0, 1'b0, 32'h60, 256'(0)});
        start_check();
        finish_txn();
        // 2: simultaneous I read and D writeback, D first
        i_read = 1'b1;
        i_address = 32'h0000_0abc;
        d_write = 1'b1;
        d_address = 32'h1234;
        d_wdata = {8{32'hdead_beef}};
        exp_q.push_back('{1'b1, 1'b1, 32'h1220, {8{32'hdead_beef}}});
        exp_q.push_back('{1'b0, 1'b0, 32'h0000_0aa0, 256'(0)});
        start_check();
        finish_txn();
        start_check();
        finish_txn();
        // 3: D keeps re-requesting while I waits; I forced in after the limit
        i_read = 1'b1;
        i_address = 32'h7f;
        d_read = 1'b1;
        d_address = 32'h2000;
        for (int k = 0; k < 4; k++) exp_q.push_back('{1'b1, 1'b0, 32'h2000, 256'(0)});
        exp_q.push_back('{1'b0, 1'b0, 32'h60, 256'(0)});
        for (int k = 0; k < 4; k++) begin
            start_check();
            finish_txn();
            d_read = 1'b1;
        end
        start_check();
        d_read = 1'b0;
        finish_txn();
        // 4: reset mid SERVE_D aborts without response
        @(negedge clk);
        d_read = 1'b1;
        d_address = 32'h400;
        @(negedge clk);
        chk("pre_rst_pmem_read", 256'(pmem_read), 256'(1));
        rst = 1'b1;
        pmem_resp = 1'b1;
        #1;
        chk("rst_abort_read", 256'(pmem_read), 256'(0));
        chk("rst_abort_write", 256'(pmem_write), 256'(0));
        chk("rst_abort_resp", 256'({i_resp, d_resp}), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        pmem_resp = 1'b0;
        exp_q.push_back('{1'b1, 1'b0, 32'h400, 256'(0)});
        start_check();
        finish_txn();
        // 5: request dropped mid-transaction still completes
        @(negedge clk);
        d_read = 1'b1;
        d_address = 32'h3456;
        exp_q.push_back('{1'b1, 1'b0, 32'h3440, 256'(0)});
        start_check();
        d_read = 1'b0;
        @(negedge clk);
        chk("held_pmem_read", 256'(pmem_read), 256'(1));
        finish_txn();
        // spurious pmem_resp while idle
        @(negedge clk);
        pmem_resp = 1'b1;
        pmem_rdata = {8{32'h5555_aaaa}};
        #1;
        chk("spurious_resp", 256'({i_resp, d_resp}), 256'(0));
        chk("spurious_rdata", i_rdata | d_rdata, 256'(0));
        @(negedge clk);
        pmem_resp = 1'b0;
        chk("idle_no_request", 256'({pmem_read, pmem_write}), 256'(0));
        chk("queue_drained", 256'(exp_q.size()), 256'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
